// File: rtl/simpleadder_pkg.sv
// rtl/simpleadder_pkg.sv - shared defaults and FSM state type for the simpleadder driver
package simpleadder_pkg;

    localparam int SA_WIDTH_DEF   = 2;
    localparam int SA_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        DONE,
        GAP
    } sa_state_t;

endpackage

// File: rtl/simpleadder_deser.sv
// rtl/simpleadder_deser.sv - MSB-first deserializer for the adder's WIDTH+1 bit serial sum
module simpleadder_deser #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    output logic [WIDTH:0]   sum,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sum <= '0;
            cnt <= '0;
        end else if (shift) begin
            sum <= {sum[WIDTH-1:0], bit_in};
            cnt <= cnt + 1'b1;
        end
    end

    // High while the shift about to happen is the final (LSB) one.
    assign last = (cnt == CW'(WIDTH));

endmodule

// File: rtl/simpleadder_driver.sv
// rtl/simpleadder_driver.sv - serializes operand pairs into the bit-serial adder and collects its sum; SIMPLEADDER_DRV_CHECK_EN adds a sum check
module simpleadder_driver
    import simpleadder_pkg::*;
#(
    parameter int WIDTH   = SA_WIDTH_DEF,
    parameter int TIMEOUT = SA_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             req_ready,
    output logic             drv_en,
    output logic             drv_a,
    output logic             drv_b,
    input  logic             mon_en,
    input  logic             mon_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_sum,
    output logic             res_timeout,
    output logic             res_err
);

    localparam int SW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] S_LAST = SW'(WIDTH - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    sa_state_t        state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [SW-1:0]    scnt;
    logic [TW-1:0]    tcnt;
    logic             accept;
    logic             deser_shift;
    logic             deser_last;
    logic [WIDTH:0]   deser_sum;

    assign accept      = (state == IDLE) && req_valid && req_ready;
    assign deser_shift = ((state == WAIT) && mon_en) || (state == RECV);
    assign res_sum     = deser_sum;

    // Cleared on accept, so a timed-out transaction reports a zero sum.
    simpleadder_deser #(.WIDTH(WIDTH)) u_deser (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .shift  (deser_shift),
        .bit_in (mon_out),
        .sum    (deser_sum),
        .last   (deser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            drv_en      <= 1'b0;
            drv_a       <= 1'b0;
            drv_b       <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            scnt        <= '0;
            tcnt        <= '0;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SEND;
                        req_ready <= 1'b0;
                        drv_en    <= 1'b1;
                        drv_a     <= req_a[WIDTH-1];
                        drv_b     <= req_b[WIDTH-1];
                        a_sh      <= req_a << 1;
                        b_sh      <= req_b << 1;
                        scnt      <= '0;
                    end
                end
                SEND: begin
                    drv_en <= 1'b0;
                    if (scnt == S_LAST) begin
                        state <= WAIT;
                        drv_a <= 1'b0;
                        drv_b <= 1'b0;
                        tcnt  <= '0;
                    end else begin
                        drv_a <= a_sh[WIDTH-1];
                        drv_b <= b_sh[WIDTH-1];
                        a_sh  <= a_sh << 1;
                        b_sh  <= b_sh << 1;
                        scnt  <= scnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mon_en) begin
                        state <= RECV;
                    end else if (tcnt == T_LAST) begin
                        state       <= DONE;
                        res_valid   <= 1'b1;
                        res_timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RECV: begin
                    if (deser_last) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state       <= GAP;
                        res_valid   <= 1'b0;
                        res_timeout <= 1'b0;
                    end
                end
                GAP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIMPLEADDER_DRV_CHECK_EN
    logic [WIDTH:0] model_sum;
    logic           err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            model_sum <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                model_sum <= {1'b0, req_a} + {1'b0, req_b};
            end
            // Compare the value the deserializer is about to hold once the LSB lands.
            if ((state == RECV) && deser_last) begin
                err_q <= ({deser_sum[WIDTH-1:0], mon_out} != model_sum);
            end else if ((state == DONE) && res_ready) begin
                err_q <= 1'b0;
            end
        end
    end

    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_simpleadder_driver.sv
// tb/tb_simpleadder_driver.sv - randomized bench for simpleadder_driver with a behavioural serial adder
module tb_simpleadder_driver;

    localparam int W = 2;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_ready;
    logic         drv_en;
    logic         drv_a;
    logic         drv_b;
    logic         mon_en;
    logic         mon_out;
    logic         res_valid;
    logic         res_ready;
    logic [W:0]   res_sum;
    logic         res_timeout;
    logic         res_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_double = 0;
    logic prev_en = 1'b0;
    int en_times[$];

    simpleadder_driver #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .drv_en      (drv_en),
        .drv_a       (drv_a),
        .drv_b       (drv_b),
        .mon_en      (mon_en),
        .mon_out     (mon_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_timeout (res_timeout),
        .res_err     (res_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (drv_en) begin
            en_times.push_back(cyc);
            if (prev_en) en_double++;
        end
        prev_en = drv_en;
    end

    // Behavioural serial adder: bits sampled on edges 0..W-1, sum MSB-first from edge W.
    int         ph = -1;
    logic [W-1:0] sa, sb, last_a, last_b;
    logic [W:0]   ssum;
    logic         mute = 1'b0;
    logic         flip = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ph = -1;
            mon_en  <= 1'b0;
            mon_out <= 1'b0;
        end else begin
            if (drv_en) begin
                ph = 0;
                sa = '0;
                sb = '0;
            end
            if (ph >= 0 && ph < W) begin
                sa = {sa[W-2:0], drv_a};
                sb = {sb[W-2:0], drv_b};
            end else if (ph >= W && ph <= 2 * W) begin
                if (ph == W) begin
                    ssum   = {1'b0, sa} + {1'b0, sb};
                    last_a = sa;
                    last_b = sb;
                end
                mon_en  <= (ph == W) && !mute;
                mon_out <= mute ? 1'b0 : (ssum[2 * W - ph] ^ (flip && ph == W));
            end else if (ph == 2 * W + 1) begin
                mon_en  <= 1'b0;
                mon_out <= 1'b0;
            end
            if (ph >= 0) ph = (ph == 2 * W + 1) ? -1 : ph + 1;
        end
    end

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W:0] sum, output logic to, output logic err,
                           output int t_valid, output bit got);
        @(negedge clk);
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        res_ready = 1'b0;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        sum = res_sum;
        to = res_timeout;
        err = res_err;
        t_valid = cyc;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        n_checks++;
        if ({drv_en, drv_a, drv_b, res_valid, res_timeout, res_err, res_sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all 0",
                     {drv_en, drv_a, drv_b, res_valid, res_timeout, res_err, res_sum});
        end
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
    endtask

    task automatic test_directed;
        logic [W-1:0] av[3] = '{2'd3, 2'd2, 2'd0};
        logic [W-1:0] bv[3] = '{2'd3, 2'd1, 2'd0};
        logic [W:0] sum;
        logic to, err;
        int tv;
        bit got;
        for (int k = 0; k < 3; k++) begin
            run_txn(av[k], bv[k], sum, to, err, tv, got);
            n_checks++;
            if (!got || sum !== {1'b0, av[k]} + {1'b0, bv[k]} || to !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_sum a=%0d b=%0d: got sum=%0d to=%b err=%b valid=%b expected sum=%0d to=0 err=0",
                         av[k], bv[k], sum, to, err, got, av[k] + bv[k]);
            end
            n_checks++;
            if (last_a !== av[k] || last_b !== bv[k]) begin
                n_fail++;
                $display("FAIL directed_serial: got a=%0d b=%0d expected a=%0d b=%0d",
                         last_a, last_b, av[k], bv[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic [W:0] sum;
        logic to, err;
        int tv;
        bit got;
        for (int k = 0; k < 8; k++) begin
            a = W'($urandom());
            b = W'($urandom());
            run_txn(a, b, sum, to, err, tv, got);
            n_checks++;
            if (!got || sum !== W'(0) + a + b || to !== 1'b0) begin
                n_fail++;
                $display("FAIL random_sum a=%0d b=%0d: got %0d (valid=%b to=%b) expected %0d",
                         a, b, sum, got, to, a + b);
            end
        end
    endtask

    task automatic test_back_to_back;
        int order[16];
        int j, tmp;
        logic [W-1:0] a, b;
        bit ok;
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        @(negedge clk);
        en_times.delete();
        res_ready = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            a = W'(order[k] >> 2);
            b = W'(order[k]);
            req_a = a;
            req_b = b;
            for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
            @(negedge clk);
            ok = 1'b0;
            for (int i = 0; i < 64; i++) begin
                if (res_valid) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            n_checks++;
            if (!ok || res_sum !== {1'b0, a} + {1'b0, b}) begin
                n_fail++;
                $display("FAIL b2b_sum a=%0d b=%0d: got %0d (valid=%b) expected %0d",
                         a, b, res_sum, ok, a + b);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        n_checks++;
        if (en_times.size() != 16) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d expected 16", en_times.size());
        end else begin
            for (int i = 1; i < 16; i++) begin
                n_checks++;
                if (en_times[i] - en_times[i-1] != 9) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d expected 9", i, en_times[i] - en_times[i-1]);
                end
            end
        end
    endtask

    task automatic test_timeout;
        logic [W:0] sum;
        logic to, err;
        int tv, lat;
        bit got;
        mute = 1'b1;
        run_txn(2'd3, 2'd2, sum, to, err, tv, got);
        mute = 1'b0;
        lat = (en_times.size() > 0) ? tv - en_times[$] : -1;
        n_checks++;
        if (!got || to !== 1'b1 || sum !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_result: got valid=%b to=%b sum=%0d err=%b expected valid=1 to=1 sum=0 err=0",
                     got, to, sum, err);
        end
        n_checks++;
        if (lat != W + T) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d expected %0d", lat, W + T);
        end
        run_txn(2'd1, 2'd2, sum, to, err, tv, got);
        n_checks++;
        if (!got || sum !== 3'd3 || to !== 1'b0) begin
            n_fail++;
            $display("FAIL after_timeout_sum: got %0d to=%b expected 3 to=0", sum, to);
        end
    endtask

    task automatic test_backpressure;
        logic [W:0] s0;
        int n0, ce;
        bit ok;
        @(negedge clk);
        req_a = 2'd1;
        req_b = 2'd3;
        req_valid = 1'b1;
        res_ready = 1'b0;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_a = 2'd2;
        req_b = 2'd2;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        s0 = res_sum;
        n0 = en_times.size();
        n_checks++;
        if (!ok || s0 !== 3'd4) begin
            n_fail++;
            $display("FAIL bp_sum: got %0d (valid=%b) expected 4", s0, ok);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_sum !== 3'd4) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b sum=%0d expected valid=1 sum=4", i, res_valid, res_sum);
            end
        end
        n_checks++;
        if (en_times.size() != n0) begin
            n_fail++;
            $display("FAIL bp_no_drv_en: got %0d pulses expected 0", en_times.size() - n0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        ce = cyc;
        res_ready = 1'b0;
        for (int i = 0; i < 20 && !drv_en; i++) @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (cyc - ce != 2) begin
            n_fail++;
            $display("FAIL bp_next_drv_en: got %0d cycles expected 2", cyc - ce);
        end
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok || res_sum !== 3'd4) begin
            n_fail++;
            $display("FAIL bp_second_sum: got %0d (valid=%b) expected 4", res_sum, ok);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [W:0] sum;
        logic to, err;
        int tv, n0;
        bit got;
        @(negedge clk);
        req_a = 2'd3;
        req_b = 2'd2;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 40 && !mon_en; i++) @(negedge clk);
        @(negedge clk);
        n0 = en_times.size();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 ||
            {drv_en, drv_a, drv_b, res_valid, res_timeout, res_err, res_sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got ready=%b rest=%b expected ready=1 rest=0",
                     req_ready, {drv_en, drv_a, drv_b, res_valid, res_timeout, res_err, res_sum});
        end
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        n_checks++;
        if (en_times.size() != n0) begin
            n_fail++;
            $display("FAIL reset_mid_drv_en: got %0d pulses expected 0", en_times.size() - n0);
        end
        run_txn(2'd2, 2'd3, sum, to, err, tv, got);
        n_checks++;
        if (!got || sum !== 3'd5) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got %0d (valid=%b) expected 5", sum, got);
        end
    endtask

    task automatic test_check;
        logic [W:0] sum;
        logic to, err;
        logic exp_err;
        int tv;
        bit got;
`ifdef SIMPLEADDER_DRV_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        flip = 1'b1;
        run_txn(2'd1, 2'd1, sum, to, err, tv, got);
        flip = 1'b0;
        n_checks++;
        if (!got || sum !== 3'd6) begin
            n_fail++;
            $display("FAIL check_flipped_sum: got %0d (valid=%b) expected 6", sum, got);
        end
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL check_res_err: got %b expected %b", err, exp_err);
        end
        run_txn(2'd1, 2'd1, sum, to, err, tv, got);
        n_checks++;
        if (!got || sum !== 3'd2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL check_clean: got sum=%0d err=%b expected sum=2 err=0", sum, err);
        end
    endtask

    task automatic test_drv_en_pulse;
        n_checks++;
        if (en_double != 0) begin
            n_fail++;
            $display("FAIL drv_en_single_cycle: got %0d multi-cycle pulses expected 0", en_double);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_check();
        test_drv_en_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
